force_accum_receiver: RTL

FORCE_ACCUM_RECEIVER -- requirements
Module: force_accum_receiver

---
 rtl/force_accum_receiver.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/force_accum_receiver.sv
// Force accumulation receiver: buffers non-stalling ring force packets and sums them per
// particle into an accumulator cache through a two-stage read/add/write pipeline.
module force_accum_receiver #(
    parameter int DATA_WIDTH        = 32,
    parameter int PARTICLE_ID_WIDTH = 7,
    parameter int CACHE_DEPTH       = 100,
    parameter int FIFO_DEPTH        = 16
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        in_valid,
    input  logic [3*DATA_WIDTH+PARTICLE_ID_WIDTH-1:0]   in_data,
    input  logic                                        clear,
    input  logic                                        rd_en,
    input  logic [PARTICLE_ID_WIDTH-1:0]                rd_addr,
    output logic [3*DATA_WIDTH-1:0]                     rd_data,
    output logic                                        rd_valid,
    output logic                                        buffer_empty,
    output logic                                        clearing,
    output logic                                        overflow,
    output logic                                        bad_id
);

    localparam int PKT_W = 3*DATA_WIDTH + PARTICLE_ID_WIDTH;
    localparam int FRC_W = 3*DATA_WIDTH;
    localparam int PID_W = PARTICLE_ID_WIDTH;
    localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    localparam logic [AW:0]      FIFO_FULL = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0]      CNT_ONE   = (AW+1)'(1);
    localparam logic [AW-1:0]    PTR_ONE   = AW'(1);
    localparam logic [PID_W:0]   DEPTH_EXT = (PID_W+1)'(CACHE_DEPTH);
    localparam logic [PID_W-1:0] LAST_IDX  = PID_W'(CACHE_DEPTH-1);
    localparam logic [PID_W-1:0] IDX_ONE   = PID_W'(1);

    typedef enum logic {CLEAR, RUN} state_t;

    state_t state, next_state;
    logic [PID_W-1:0] clr_cnt;
    logic             clr_we;

    // Input FIFO
    logic [PKT_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;
    logic             fifo_empty, fifo_full, push, pop;

    logic [PKT_W-1:0] head;
    logic [PID_W-1:0] head_pid;
    logic [FRC_W-1:0] head_frc;
    logic             head_ok;

    // Accumulator cache and pipeline
    logic [FRC_W-1:0] acc_mem [CACHE_DEPTH];
    logic             s2_valid, s2_we;
    logic [PID_W-1:0] s2_pid;
    logic [FRC_W-1:0] s2_frc, s2_base, s2_sum, fwd_base;

    logic             rd_ok;
    logic [FRC_W-1:0] rd_value;

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) state <= CLEAR;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        clearing   = 1'b0;
        clr_we     = 1'b0;
        case (state)
            CLEAR: begin
                clearing = 1'b1;
                clr_we   = 1'b1;
                if (clr_cnt == LAST_IDX) next_state = RUN;
            end
            RUN: ;
            default: next_state = CLEAR;
        endcase
        if (clear) next_state = CLEAR;
    end

    always_ff @(posedge clk) begin
        if (rst || clear)        clr_cnt <= '0;
        else if (state == CLEAR) clr_cnt <= (clr_cnt == LAST_IDX) ? '0 : clr_cnt + IDX_ONE;
    end

    // ---------------- FIFO ----------------
    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == FIFO_FULL);
    assign pop        = (state == RUN) && !clear && !rd_en && !fifo_empty;
    assign push       = in_valid && (!fifo_full || pop);

    assign head     = fifo_mem[rd_ptr];
    assign head_pid = head[PID_W-1:0];
    assign head_frc = head[PKT_W-1:PID_W];
    assign head_ok  = ({1'b0, head_pid} < DEPTH_EXT);

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= in_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // ---------------- Accumulate pipeline ----------------
    assign s2_we = s2_valid && (state == RUN) && !clear && !rst;

    always_comb begin
        s2_sum = '0;
        for (int unsigned k = 0; k < 3; k++) begin
            s2_sum[k*DATA_WIDTH +: DATA_WIDTH] =
                s2_base[k*DATA_WIDTH +: DATA_WIDTH] + s2_frc[k*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // The cache read issued at pop misses the S2 write landing the same edge, so that
    // write is bypassed into the captured base instead.
    always_comb begin
        fwd_base = '0;
        if (s2_we && (s2_pid == head_pid)) fwd_base = s2_sum;
        else if (head_ok)                  fwd_base = acc_mem[head_pid];
    end

    always_ff @(posedge clk) begin
        if (rst || clear) s2_valid <= 1'b0;
        else              s2_valid <= pop && head_ok;
        if (pop) begin
            s2_pid  <= head_pid;
            s2_frc  <= head_frc;
            s2_base <= fwd_base;
        end
    end

    always_ff @(posedge clk) begin
        if (clr_we)     acc_mem[clr_cnt] <= '0;
        else if (s2_we) acc_mem[s2_pid]  <= s2_sum;
    end

    // ---------------- Read port ----------------
    assign rd_ok = ({1'b0, rd_addr} < DEPTH_EXT);

    always_comb begin
        rd_value = '0;
        if (state == RUN && rd_ok) begin
            if (s2_we && (s2_pid == rd_addr)) rd_value = s2_sum;
            else                              rd_value = acc_mem[rd_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) rd_data <= rd_value;
        end
    end

    // ---------------- Status ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
            bad_id   <= 1'b0;
        end else begin
            if (in_valid && !push) overflow <= 1'b1;
            if (pop && !head_ok)   bad_id   <= 1'b1;
        end
    end

    assign buffer_empty = fifo_empty && !s2_valid && (state == RUN);

endmodule
